// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the multi-channel PWM block.
//   MODE_EDGE / MODE_CENTER : encodings of the mode input and active mode
//   dir_e                   : period counter direction
//   sat_add / sat_sub       : saturating duty arithmetic for a WIDTH-bit range
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_e;

  // Clamp at 2^width-1 instead of wrapping.
  function automatic int unsigned sat_add(input int unsigned val,
                                          input int unsigned step,
                                          input int unsigned width);
    int unsigned max;
    max = (32'd1 << width) - 32'd1;
    return (val + step > max) ? max : val + step;
  endfunction

  // Clamp at 0 instead of wrapping. The width argument keeps the call
  // signature symmetric with sat_add.
  function automatic int unsigned sat_sub(input int unsigned val,
                                          input int unsigned step,
                                          input int unsigned width);
    int unsigned max;
    max = (32'd1 << width) - 32'd1;
    return (val < step) ? 32'd0 : ((val - step) & max);
  endfunction

endpackage

// File: rtl/pwm_multi_ch_if.sv
// pwm_multi_ch_if: control/observe bundle of the multi-channel PWM.
//   ena, inc, dec, ch_sel, mode : driven by the master (buttons / tt pins)
//   pwm, duty_rd, period_tick   : driven by the PWM block (slave)
interface pwm_multi_ch_if #(
  parameter int CH    = 4,
  parameter int WIDTH = 8
) ();
  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;

  logic             ena;
  logic             inc;
  logic             dec;
  logic [SEL_W-1:0] ch_sel;
  logic             mode;
  logic [CH-1:0]    pwm;
  logic [WIDTH-1:0] duty_rd;
  logic             period_tick;

  modport master (output ena, inc, dec, ch_sel, mode,
                  input  pwm, duty_rd, period_tick);
  modport slave  (input  ena, inc, dec, ch_sel, mode,
                  output pwm, duty_rd, period_tick);
endinterface

// File: rtl/pwm_btn_sync.sv
// pwm_btn_sync: 2-flop synchroniser followed by a rising-edge detector.
//   clk, rst_n : clock, async active-low reset
//   din        : raw button, asynchronous to clk
//   pulse      : one-cycle pulse per low->high transition of din
// No debounce; a clean button is expected.
module pwm_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  // sr[0] may go metastable, sr[1] is the synchronised level, sr[2] its
  // previous value for edge detection.
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], din};
  end

  assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: CH-channel PWM with a shared edge/centre-aligned counter.
//   clk, rst_n  : clock, async active-low reset
//   bus.ena     : block enable; low parks the counter and silences outputs
//   bus.inc/dec : raw duty up/down buttons applied to channel bus.ch_sel
//   bus.mode    : requested alignment, adopted at the next period boundary
//   bus.pwm     : registered PWM outputs, bit i = channel i
//   bus.duty_rd : committed duty of channel bus.ch_sel (combinational)
//   bus.period_tick : high in the boundary cycle of each period
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int CH        = 4,
  parameter int WIDTH     = 8,
  parameter int STEP      = 16,
  parameter int DUTY_INIT = 128
) (
  input logic           clk,
  input logic           rst_n,
  pwm_multi_ch_if.slave bus
);
  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] D_INIT  = WIDTH'(DUTY_INIT);

  logic inc_p, dec_p, btn_ok;

  pwm_btn_sync u_inc (.clk(clk), .rst_n(rst_n), .din(bus.inc), .pulse(inc_p));
  pwm_btn_sync u_dec (.clk(clk), .rst_n(rst_n), .din(bus.dec), .pulse(dec_p));

  logic [CH-1:0][WIDTH-1:0] duty, shadow;
  logic [WIDTH-1:0]         cnt, cnt_nxt;
  dir_e                     dir, dir_nxt;
  logic                     mode_act;
  logic                     restart;   // cnt sits at 0 after ena-low or a mode switch
  logic                     boundary, mode_sw;
  logic [CH-1:0]            pwm_q;

  // Simultaneous inc and dec cancel out; presses are ignored while disabled.
  assign btn_ok = bus.ena & (inc_p ^ dec_p);

  // Period boundary: end of an edge period, the bottom turnaround of a
  // centre period, or the first cycle after the counter was restarted.
  always_comb begin
    boundary = 1'b0;
    if (bus.ena) begin
      if (restart)                    boundary = 1'b1;
      else if (mode_act == MODE_EDGE) boundary = (cnt == CNT_MAX);
      else                            boundary = (cnt == '0) && (dir == DIR_DN);
    end
    mode_sw = boundary & (bus.mode != mode_act);
  end

  // Counter / direction next state. Centre mode visits each end once: the
  // direction flips in the same cycle the end value is shown.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (!bus.ena || mode_sw) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (mode_act == MODE_EDGE) begin
      cnt_nxt = cnt + 1'b1;
      dir_nxt = DIR_UP;
    end else if (dir == DIR_UP) begin
      if (cnt == CNT_MAX) begin
        cnt_nxt = cnt - 1'b1;
        dir_nxt = DIR_DN;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else begin
      if (cnt == '0) begin
        cnt_nxt = cnt + 1'b1;
        dir_nxt = DIR_UP;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty     <= {CH{D_INIT}};
      shadow   <= {CH{D_INIT}};
      cnt      <= '0;
      dir      <= DIR_UP;
      mode_act <= MODE_EDGE;
      restart  <= 1'b0;
      pwm_q    <= '0;
    end else begin
      cnt     <= cnt_nxt;
      dir     <= dir_nxt;
      restart <= ~bus.ena | mode_sw;
      if (boundary) begin
        shadow   <= duty;
        mode_act <= bus.mode;
      end
      for (int i = 0; i < CH; i++) begin
        pwm_q[i] <= bus.ena & (cnt < shadow[i]);
        if (btn_ok && bus.ch_sel == SEL_W'(i))
          duty[i] <= inc_p ? WIDTH'(sat_add(32'(duty[i]), STEP, WIDTH))
                           : WIDTH'(sat_sub(32'(duty[i]), STEP, WIDTH));
      end
    end
  end

  always_comb begin
    bus.duty_rd = '0;
    for (int i = 0; i < CH; i++)
      if (bus.ch_sel == SEL_W'(i)) bus.duty_rd = duty[i];
  end

  assign bus.pwm         = pwm_q;
  assign bus.period_tick = boundary;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: scenario tasks against a duty/period reference model.
module tb_pwm_multi_ch;
  localparam int CH = 4, WIDTH = 8, STEP = 16, DUTY_INIT = 128;
  localparam int MAX = (1 << WIDTH) - 1;
  localparam int SEL_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pwm_multi_ch_if #(.CH(CH), .WIDTH(WIDTH)) bus ();

  pwm_multi_ch #(.CH(CH), .WIDTH(WIDTH), .STEP(STEP), .DUTY_INIT(DUTY_INIT))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int duty_m [CH];
  int hi_cnt [CH];

  // Reference duty rule: saturating step, inc+dec together is a no-op.
  function automatic int next_duty(int d, bit up, bit dn);
    if (up && !dn) return (d + STEP > MAX) ? MAX : d + STEP;
    if (dn && !up) return (d < STEP) ? 0 : d - STEP;
    return d;
  endfunction

  // High cycles per period: edge counts 0..MAX once each; centre period is
  // the triangle 0..MAX..1 of length 2*MAX.
  function automatic int exp_high(int d, bit centre);
    int c = 0;
    int v;
    if (!centre) begin
      for (int p = 0; p <= MAX; p++) if (p < d) c++;
    end else begin
      for (int p = 0; p < 2 * MAX; p++) begin
        v = (p <= MAX) ? p : 2 * MAX - p;
        if (v < d) c++;
      end
    end
    return c;
  endfunction

  task automatic wait_tick(output int n);
    bit seen = 1'b0;
    n = 0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      if (bus.period_tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no period_tick within %0d cycles", n);
    end
  endtask

  // Counts pwm high cycles per channel over n cycles, starting one cycle
  // after the caller's tick; optionally presses inc on press_ch at press_at.
  task automatic measure(input int n, input int press_ch, input int press_at);
    for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) if (bus.pwm[c] === 1'b1) hi_cnt[c]++;
      if (k == press_at) begin bus.ch_sel = SEL_W'(press_ch); bus.inc = 1'b1; end
      if (k == press_at + 4) bus.inc = 1'b0;
    end
  endtask

  task automatic press(input int ch, input bit up, input bit dn);
    @(negedge clk);
    bus.ch_sel = SEL_W'(ch);
    bus.inc = up;
    bus.dec = dn;
    repeat (4) @(negedge clk);
    bus.inc = 1'b0;
    bus.dec = 1'b0;
    repeat (3) @(negedge clk);
    if (bus.ena) duty_m[ch] = next_duty(duty_m[ch], up, dn);
  endtask

  task automatic test_reset();
    int n;
    bus.ena = 1'b1; bus.inc = 1'b0; bus.dec = 1'b0; bus.mode = 1'b0; bus.ch_sel = '0;
    rst_n = 1'b0;
    for (int c = 0; c < CH; c++) duty_m[c] = DUTY_INIT;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pwm !== '0 || bus.period_tick !== 1'b0) begin
      errors++; $display("FAIL reset_out: pwm=%b tick=%b want 0/0", bus.pwm, bus.period_tick);
    end
    for (int c = 0; c < CH; c++) begin
      bus.ch_sel = SEL_W'(c); #1;
      checks++;
      if (bus.duty_rd !== WIDTH'(DUTY_INIT)) begin
        errors++; $display("FAIL reset_duty ch%0d: got %0d want %0d", c, bus.duty_rd, DUTY_INIT);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(n);
    checks++;
    if (n != MAX) begin errors++; $display("FAIL first_tick: got %0d want %0d", n, MAX); end
    wait_tick(n);
    checks++;
    if (n != MAX + 1) begin errors++; $display("FAIL edge_period: got %0d want %0d", n, MAX + 1); end
    measure(MAX + 1, -1, -1);
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (hi_cnt[c] != exp_high(duty_m[c], 1'b0)) begin
        errors++; $display("FAIL reset_pwm ch%0d: got %0d want %0d", c, hi_cnt[c], exp_high(duty_m[c], 1'b0));
      end
    end
  endtask

  task automatic test_inc_dec();
    int n;
    int old;
    @(negedge clk);
    bus.ch_sel = SEL_W'(2);
    for (int r = 0; r < 3; r++) begin
      old = duty_m[2];
      @(negedge clk); bus.inc = 1'b1;
      @(negedge clk); @(negedge clk);
      checks++;
      if (bus.duty_rd !== WIDTH'(old)) begin
        errors++; $display("FAIL inc_early r%0d: got %0d want %0d", r, bus.duty_rd, old);
      end
      @(negedge clk);
      duty_m[2] = next_duty(old, 1'b1, 1'b0);
      checks++;
      if (bus.duty_rd !== WIDTH'(duty_m[2])) begin
        errors++; $display("FAIL inc_lat r%0d: got %0d want %0d", r, bus.duty_rd, duty_m[2]);
      end
      bus.inc = 1'b0;
      repeat (3) @(negedge clk);
    end
    for (int c = 0; c < CH; c++) begin
      bus.ch_sel = SEL_W'(c); #1;
      checks++;
      if (bus.duty_rd !== WIDTH'(duty_m[c])) begin
        errors++; $display("FAIL inc_other ch%0d: got %0d want %0d", c, bus.duty_rd, duty_m[c]);
      end
    end
    // A press mid-period must not reach pwm until the next boundary.
    wait_tick(n);
    old = duty_m[2];
    measure(MAX + 1, 2, 0);
    duty_m[2] = next_duty(old, 1'b1, 1'b0);
    checks++;
    if (hi_cnt[2] != exp_high(old, 1'b0)) begin
      errors++; $display("FAIL shadow_hold: got %0d want %0d", hi_cnt[2], exp_high(old, 1'b0));
    end
    wait_tick(n);
    measure(MAX + 1, -1, -1);
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (hi_cnt[c] != exp_high(duty_m[c], 1'b0)) begin
        errors++; $display("FAIL shadow_load ch%0d: got %0d want %0d", c, hi_cnt[c], exp_high(duty_m[c], 1'b0));
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    for (int r = 0; r < 9; r++) press(0, 1'b1, 1'b0);
    bus.ch_sel = SEL_W'(0); #1;
    checks++;
    if (bus.duty_rd !== WIDTH'(MAX) || duty_m[0] != MAX) begin
      errors++; $display("FAIL sat_hi: got %0d model %0d want %0d", bus.duty_rd, duty_m[0], MAX);
    end
    for (int r = 0; r < 17; r++) press(0, 1'b0, 1'b1);
    bus.ch_sel = SEL_W'(0); #1;
    checks++;
    if (bus.duty_rd !== '0 || duty_m[0] != 0) begin
      errors++; $display("FAIL sat_lo: got %0d model %0d want 0", bus.duty_rd, duty_m[0]);
    end
    press(0, 1'b1, 1'b1);
    press(3, 1'b1, 1'b1);
    for (int c = 0; c < CH; c++) begin
      bus.ch_sel = SEL_W'(c); #1;
      checks++;
      if (bus.duty_rd !== WIDTH'(duty_m[c])) begin
        errors++; $display("FAIL both_btn ch%0d: got %0d want %0d", c, bus.duty_rd, duty_m[c]);
      end
    end
    wait_tick(n);
    measure(MAX + 1, -1, -1);
    checks++;
    if (hi_cnt[0] != 0) begin errors++; $display("FAIL duty0_low: got %0d want 0", hi_cnt[0]); end
  endtask

  task automatic test_random();
    int n, ch, op;
    for (int r = 0; r < 24; r++) begin
      ch = $urandom_range(CH - 1, 0);
      op = $urandom_range(2, 0);
      press(ch, op != 1, op != 0);
      bus.ch_sel = SEL_W'(ch); #1;
      checks++;
      if (bus.duty_rd !== WIDTH'(duty_m[ch])) begin
        errors++; $display("FAIL rand_duty r%0d ch%0d op%0d: got %0d want %0d", r, ch, op, bus.duty_rd, duty_m[ch]);
      end
    end
    wait_tick(n);
    wait_tick(n);
    measure(MAX + 1, -1, -1);
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (hi_cnt[c] != exp_high(duty_m[c], 1'b0)) begin
        errors++; $display("FAIL rand_pwm ch%0d: got %0d want %0d", c, hi_cnt[c], exp_high(duty_m[c], 1'b0));
      end
    end
  endtask

  task automatic test_enable();
    int n;
    wait_tick(n);
    repeat (100) @(negedge clk);
    bus.ena = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.pwm !== '0 || bus.period_tick !== 1'b0) begin
        errors++; $display("FAIL ena_off k%0d: pwm=%b tick=%b want 0/0", k, bus.pwm, bus.period_tick);
      end
      @(negedge clk);
    end
    press(1, 1'b1, 1'b0);
    for (int c = 0; c < CH; c++) begin
      bus.ch_sel = SEL_W'(c); #1;
      checks++;
      if (bus.duty_rd !== WIDTH'(duty_m[c])) begin
        errors++; $display("FAIL ena_hold ch%0d: got %0d want %0d", c, bus.duty_rd, duty_m[c]);
      end
    end
    @(negedge clk);
    bus.ena = 1'b1; #1;
    checks++;
    if (bus.period_tick !== 1'b1) begin errors++; $display("FAIL ena_start_tick: got %b want 1", bus.period_tick); end
    wait_tick(n);
    checks++;
    if (n != MAX) begin errors++; $display("FAIL ena_first_period: got %0d want %0d", n, MAX); end
    measure(MAX + 1, -1, -1);
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (hi_cnt[c] != exp_high(duty_m[c], 1'b0)) begin
        errors++; $display("FAIL ena_pwm ch%0d: got %0d want %0d", c, hi_cnt[c], exp_high(duty_m[c], 1'b0));
      end
    end
  endtask

  task automatic test_centre();
    int n;
    for (int r = 0; r < 16; r++) press(1, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) press(1, 1'b1, 1'b0);
    checks++;
    if (duty_m[1] != 64) begin errors++; $display("FAIL centre_setup: model %0d want 64", duty_m[1]); end
    wait_tick(n);
    repeat (50) @(negedge clk);
    bus.mode = 1'b1;
    wait_tick(n);
    checks++;
    if (n != MAX + 1 - 50) begin errors++; $display("FAIL switch_wait: got %0d want %0d", n, MAX + 1 - 50); end
    wait_tick(n);
    checks++;
    if (n != 1) begin errors++; $display("FAIL switch_entry: got %0d want 1", n); end
    wait_tick(n);
    checks++;
    if (n != 2 * MAX) begin errors++; $display("FAIL centre_period: got %0d want %0d", n, 2 * MAX); end
    measure(2 * MAX, -1, -1);
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (hi_cnt[c] != exp_high(duty_m[c], 1'b1)) begin
        errors++; $display("FAIL centre_pwm ch%0d: got %0d want %0d", c, hi_cnt[c], exp_high(duty_m[c], 1'b1));
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (37) @(negedge clk);
    rst_n = 1'b0; #1;
    checks++;
    if (bus.pwm !== '0 || bus.period_tick !== 1'b0) begin
      errors++; $display("FAIL rst_mid_out: pwm=%b tick=%b want 0/0", bus.pwm, bus.period_tick);
    end
    for (int c = 0; c < CH; c++) begin
      duty_m[c] = DUTY_INIT;
      bus.ch_sel = SEL_W'(c); #1;
      checks++;
      if (bus.duty_rd !== WIDTH'(DUTY_INIT)) begin
        errors++; $display("FAIL rst_mid_duty ch%0d: got %0d want %0d", c, bus.duty_rd, DUTY_INIT);
      end
    end
    bus.mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_inc_dec();
    test_saturation();
    test_random();
    test_enable();
    test_centre();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
